pcm_playback_buffer: RTL and testbench
======================================

Name: pcm_playback_buffer

Overview:
- Synthesizable, parametrised successor to the codec playback path.
- Buffers multi-channel PCM samples from a producer over a valid/ready handshake.
- Presents exactly one sample set per audio frame on a frame-rate strobe, generated from an internal frame-period counter.
- Adds priming, a selectable underrun policy, underrun statistics and automatic re-priming. Sits between the tone/sample generator and the codec serializer.

Parameters:
- SAMPLE_W, 16: bits per channel sample.
- CHANNELS, 2: channels per frame. Channel 0 is in the MSBs of a frame word.
- DEPTH, 16: FIFO depth in frames. Power of two, >=2.
- FRAME_CYCLES, 32: ClkIn cycles per audio frame, >=4.
- PRIME_LEVEL, 4: frames that must be buffered before playback starts. Range 1..DEPTH.
- UNDERRUN_MODE, 0: 0 = repeat last output frame on underrun; 1 = output all-zero frame.
- REPRIME_AFTER, 8: consecutive underruns that force a return to PRIME. 0 = never.

Ports:
- ClkIn, input, 1: sole clock.
- Reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: playback enable. Low flushes the FIFO and idles the block.
- in_data, input, CHANNELS*SAMPLE_W: producer frame.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: FIFO can accept a frame.
- out_data, output, CHANNELS*SAMPLE_W: frame presented to the codec. Changes only with out_strobe.
- out_strobe, output, 1: one-cycle pulse, once per frame period, while playing.
- playing, output, 1: state == PLAY.
- level, output, $clog2(DEPTH+1): frames currently in the FIFO.
- underrun_clear, input, 1: clears underrun_sticky and underrun_count.
- underrun_sticky, output, 1: set on any underrun.
- underrun_count, output, 16: total underruns, saturating at 16'hFFFF.

Behaviour:
- Reset asserted: all outputs and internal state go to 0 immediately (in_ready = 0, state IDLE, FIFO empty, frame counter 0).
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps, only while enable = 1. Held at 0 while enable = 0.
  - tick = enable && (counter == FRAME_CYCLES-1).
- FIFO:
  - Push when in_valid && in_ready, with in_ready = enable && !full.
  - A push is refused when full, even if a pop occurs in the same cycle.
  - No fall-through: a push and a tick in the same cycle with the FIFO empty is treated as an underrun. The pushed frame is stored.
  - level is updated the cycle after a push/pop. A simultaneous push and pop leaves level unchanged.
- States (2-bit):
  - IDLE -> PRIME when enable = 1.
  - PRIME -> PLAY on a tick with level >= PRIME_LEVEL. That tick performs no pop and no strobe.
  - PLAY -> PRIME when the consecutive-underrun count reaches REPRIME_AFTER (REPRIME_AFTER != 0).
  - Any state -> IDLE when enable = 0: FIFO flushed and counters reset in that same cycle. out_data, underrun_sticky and underrun_count are held.
- On a tick in PLAY:
  - If FIFO not empty: pop. out_data <= head frame, and the consecutive-underrun counter clears.
  - If FIFO empty: underrun.
    - out_data <= out_data (mode 0) or 0 (mode 1).
    - underrun_sticky <= 1.
    - underrun_count increments (saturating).
    - The consecutive-underrun counter increments.
  - out_data and out_strobe update in the cycle after the tick. Strobe latency from tick is 1; strobe period is FRAME_CYCLES.
- underrun_clear:
  - Takes effect next cycle.
  - If it coincides with an underrun, the result is sticky = 1 and count = 1.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded.

Decomposition:
- Package pcm_pkg holds:
  - state encoding: IDLE = 0, PRIME = 1, PLAY = 2;
  - UNDERRUN_MODE constants HOLD = 0 and ZERO = 1;
  - the count width constant (16).
- One sub-module, sync_fifo (parametrised width/depth, pointers with an extra wrap bit, outputs full/empty/level, flush input).
- The frame counter and FSM stay in the top module.

Test Plan (defaults):
- Prime: enable = 1, push 4 frames 32'h0001_0002..32'h0004_0005 → playing rises at first tick. First strobe one frame period later carries 32'h0001_0002, then one frame per 32 cycles in order.
- Backpressure: push 20 frames back-to-back in PRIME → in_ready low after 16 accepted, level = 16. Frames 17..20 not accepted until a pop occurs.
- Underrun hold: after the FIFO drains with last frame 32'h1234_5678, the next strobe repeats 32'h1234_5678, underrun_sticky = 1 and underrun_count = 1. In mode 1 the same case outputs 32'h0.
- Re-prime: starve for 8 ticks → underrun_count = 8, playing falls after the 8th. Push 4 frames → PLAY resumes at the next tick.
- Clear/simultaneous: underrun_clear coincident with an underrun tick → sticky = 1, count = 1. Clear alone → both 0.
- Async reset and disable: Reset mid-frame (counter = 13) → outputs 0 in the same cycle without a clock edge. enable = 0 with level = 9 → level = 0 next cycle, out_data held.

Source files
------------

// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM playback buffer.
package pcm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StPlay  = 2'd2
  } state_e;

  // Underrun output policy.
  localparam int unsigned UnderrunHold = 0;
  localparam int unsigned UnderrunZero = 1;

  // Width of the underrun statistics counters.
  localparam int unsigned CountW = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy output and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Same slot, different lap: the writer is a whole buffer ahead.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pcm_playback_buffer.sv
// Buffers producer PCM frames and releases one per frame period, with priming,
// underrun handling, underrun statistics and automatic re-priming.
module pcm_playback_buffer
  import pcm_pkg::*;
#(
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FRAME_CYCLES  = 32,
  parameter int unsigned PRIME_LEVEL   = 4,
  parameter int unsigned UNDERRUN_MODE = 0,
  parameter int unsigned REPRIME_AFTER = 8
) (
  input  logic                              ClkIn,
  input  logic                              Reset,
  input  logic                              enable,
  input  logic [CHANNELS*SAMPLE_W-1:0]      in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [CHANNELS*SAMPLE_W-1:0]      out_data,
  output logic                              out_strobe,
  output logic                              playing,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  input  logic                              underrun_clear,
  output logic                              underrun_sticky,
  output logic [15:0]                       underrun_count
);

  localparam int unsigned FrameW = CHANNELS * SAMPLE_W;
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned CntW   = $clog2(FRAME_CYCLES);

  state_e              state_q, state_d;
  logic [CntW-1:0]     frame_cnt_q;
  logic                tick;
  logic                fifo_full, fifo_empty;
  logic [FrameW-1:0]   fifo_rdata;
  logic [LevelW-1:0]   fifo_level;
  logic                pop, underrun, reprime;
  logic [CountW-1:0]   consec_q;
  logic [FrameW-1:0]   out_data_q;
  logic                out_strobe_q;
  logic                sticky_q;
  logic [CountW-1:0]   count_q;

  assign tick     = enable && (frame_cnt_q == CntW'(FRAME_CYCLES - 1));
  assign in_ready = enable && !fifo_full && !Reset;
  assign pop      = (state_q == StPlay) && tick && !fifo_empty;
  // An empty FIFO at a tick is an underrun even if a push lands in the same cycle.
  assign underrun = (state_q == StPlay) && tick && fifo_empty;
  assign reprime  = (REPRIME_AFTER != 0) &&
                    (32'(consec_q) + 32'd1 >= REPRIME_AFTER);

  sync_fifo #(
    .WIDTH (FrameW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ClkIn),
    .rst   (Reset),
    .flush (!enable),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Frame-period counter, held at zero while disabled.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else if (!enable || tick) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + CntW'(1);
    end
  end

  // State register.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disable wins from any state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: if (tick && (fifo_level >= LevelW'(PRIME_LEVEL))) state_d = StPlay;
        StPlay:  if (underrun && reprime) state_d = StPrime;
        default: state_d = StIdle;
      endcase
    end
  end

  // Consecutive-underrun run length, only meaningful while playing.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      consec_q <= '0;
    end else if (state_q != StPlay || !enable || pop) begin
      consec_q <= '0;
    end else if (underrun && consec_q != '1) begin
      consec_q <= consec_q + 1'b1;
    end
  end

  // Output frame and strobe, one cycle after the tick.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      out_strobe_q <= (state_q == StPlay) && tick;
      if (pop) begin
        out_data_q <= fifo_rdata;
      end else if (underrun && UNDERRUN_MODE == UnderrunZero) begin
        out_data_q <= '0;
      end
    end
  end

  // Underrun statistics; a clear that meets an underrun records that underrun.
  always_ff @(posedge ClkIn or posedge Reset) begin
    if (Reset) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (underrun_clear) begin
      sticky_q <= underrun;
      count_q  <= underrun ? CountW'(1) : '0;
    end else if (underrun) begin
      sticky_q <= 1'b1;
      if (count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign out_data        = out_data_q;
  assign out_strobe      = out_strobe_q;
  assign playing         = (state_q == StPlay);
  assign level           = fifo_level;
  assign underrun_sticky = sticky_q;
  assign underrun_count  = count_q;

endmodule

// File: tb/tb_pcm_playback_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed sequences for priming, backpressure, underrun, re-prime, clear, disable, reset.
module tb_pcm_playback_buffer;

  localparam int unsigned SW = 16, CH = 2, DEPTH = 16, FC = 32, PL = 4, RA = 8;
  localparam int unsigned FW = SW * CH;
  localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2;

  logic          clk = 1'b0, rst = 1'b0, enable = 1'b0, in_valid = 1'b0, uclr = 1'b0;
  logic [FW-1:0] in_data = '0;

  logic          in_ready, out_strobe, playing, sticky;
  logic [FW-1:0] out_data;
  logic [4:0]    level;
  logic [15:0]   ucount;
  logic          in_ready1, out_strobe1, playing1, sticky1;
  logic [FW-1:0] out_data1;
  logic [4:0]    level1;
  logic [15:0]   ucount1;

  pcm_playback_buffer #(
    .SAMPLE_W(SW), .CHANNELS(CH), .DEPTH(DEPTH), .FRAME_CYCLES(FC),
    .PRIME_LEVEL(PL), .UNDERRUN_MODE(0), .REPRIME_AFTER(RA)
  ) dut (
    .ClkIn(clk), .Reset(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_strobe(out_strobe), .playing(playing),
    .level(level), .underrun_clear(uclr), .underrun_sticky(sticky), .underrun_count(ucount)
  );

  pcm_playback_buffer #(
    .SAMPLE_W(SW), .CHANNELS(CH), .DEPTH(DEPTH), .FRAME_CYCLES(FC),
    .PRIME_LEVEL(PL), .UNDERRUN_MODE(1), .REPRIME_AFTER(RA)
  ) dut_zero (
    .ClkIn(clk), .Reset(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_strobe(out_strobe1), .playing(playing1),
    .level(level1), .underrun_clear(uclr), .underrun_sticky(sticky1), .underrun_count(ucount1)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [FW-1:0] mq[$];
  int            m_cnt = 0, m_state = M_IDLE, m_consec = 0, m_ucount = 0;
  bit            m_strobe = 0, m_sticky = 0;
  logic [FW-1:0] m_out = '0, m_out1 = '0;

  task automatic model_step();
    bit tick, ur, take, was_empty;
    tick      = enable && (m_cnt == FC - 1);
    take      = in_valid && enable && (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    ur        = 0;
    m_strobe  = 0;
    if (!enable) begin
      mq.delete();
      m_cnt = 0; m_state = M_IDLE; m_consec = 0;
    end else begin
      if (m_state == M_PLAY && tick) begin
        m_strobe = 1;
        if (!was_empty) begin
          m_out = mq.pop_front(); m_out1 = m_out; m_consec = 0;
        end else begin
          ur = 1; m_out1 = '0; m_consec++;
          if (RA != 0 && m_consec >= RA) begin m_state = M_PRIME; m_consec = 0; end
        end
      end else if (m_state == M_PRIME && tick && mq.size() >= PL) begin
        m_state = M_PLAY;
      end else if (m_state == M_IDLE) begin
        m_state = M_PRIME;
      end
      if (take) mq.push_back(in_data);
      m_cnt = tick ? 0 : m_cnt + 1;
    end
    if (uclr) begin
      m_sticky = ur; m_ucount = ur ? 1 : 0;
    end else if (ur) begin
      m_sticky = 1;
      if (m_ucount < 65535) m_ucount++;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_state = M_IDLE; m_consec = 0; m_ucount = 0;
      m_strobe = 0; m_sticky = 0; m_out = '0; m_out1 = '0;
    end else begin
      model_step();
    end
  end

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !rst && enable && (mq.size() < DEPTH);
    check("m_in_ready", in_ready, exp_ready);
    check("m_out_data", out_data, m_out);
    check("m_out_strobe", out_strobe, m_strobe);
    check("m_playing", playing, m_state == M_PLAY);
    check("m_level", level, mq.size());
    check("m_sticky", sticky, m_sticky);
    check("m_count", ucount, m_ucount);
    check("z_in_ready", in_ready1, exp_ready);
    check("z_out_data", out_data1, m_out1);
    check("z_out_strobe", out_strobe1, m_strobe);
    check("z_playing", playing1, m_state == M_PLAY);
    check("z_level", level1, mq.size());
    check("z_sticky", sticky1, m_sticky);
    check("z_count", ucount1, m_ucount);
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; uclr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int bound, output int at);
    bit found = 0;
    at = -1;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge clk);
      if (out_strobe === 1'b1) begin found = 1; at = cyc_n; end
    end
    if (!found) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_playing(input int bound, output int at);
    bit found = 0;
    at = -1;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge clk);
      if (playing === 1'b1) begin found = 1; at = cyc_n; end
    end
    if (!found) check("playing_timeout", 0, 1);
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [FW-1:0] data;
    bit            ready;
    int            level;
  } bp_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] prime_tbl[4];
    bp_vec_t       bp_tbl[20];
    int            t0, at, rate;

    prime_tbl[0] = 32'h0001_0002; prime_tbl[1] = 32'h0002_0003;
    prime_tbl[2] = 32'h0003_0004; prime_tbl[3] = 32'h0004_0005;
    for (int i = 0; i < 20; i++) begin
      bp_tbl[i].data  = 32'hB000_0000 + i;
      bp_tbl[i].ready = (i < 16);
      bp_tbl[i].level = (i < 16) ? i : 16;
    end

    #1 rst = 1'b1;
    step();
    check("reset_playing", playing, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_level", level, 0);
    rst = 1'b0;

    // Priming, in-order playback, hold underrun, re-prime, clear.
    do_reset();
    enable = 1'b1; t0 = cyc_n;
    for (int i = 0; i < 4; i++) push_frame(prime_tbl[i]);
    wait_playing(60, at);
    check("prime_play_cycle", at - t0, 32);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(40, at);
      check("prime_strobe_cycle", at - t0, 64 + 32 * i);
      check("prime_data", out_data, prime_tbl[i]);
    end
    step();
    push_frame(32'h1234_5678);
    wait_strobe(40, at);
    check("hold_pre_data", out_data, 32'h1234_5678);
    wait_strobe(40, at);
    check("hold_cycle", at - t0, 224);
    check("hold_data", out_data, 32'h1234_5678);
    check("zero_mode_data", out_data1, 0);
    check("hold_sticky", sticky, 1);
    check("hold_count", ucount, 1);
    for (int i = 1; i < 8; i++) begin
      wait_strobe(40, at);
      check("starve_count", ucount, i + 1);
      check("starve_playing", playing, i < 7);
    end
    step();
    for (int i = 0; i < 4; i++) push_frame(32'hA000_0001 + i);
    wait_playing(40, at);
    check("resume_cycle", at - t0, 480);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(40, at);
      check("resume_data", out_data, 32'hA000_0001 + i);
    end
    while (cyc_n < t0 + 639) step();
    uclr = 1'b1;
    step();
    uclr = 1'b0;
    check("clr_tick_strobe", out_strobe, 1);
    check("clr_coinc_sticky", sticky, 1);
    check("clr_coinc_count", ucount, 1);
    uclr = 1'b1;
    step();
    uclr = 1'b0;
    check("clr_alone_sticky", sticky, 0);
    check("clr_alone_count", ucount, 0);

    // Backpressure, table-driven.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = bp_tbl[i].data;
      @(negedge clk);
      check("bp_in_ready", in_ready, bp_tbl[i].ready);
      check("bp_level", level, bp_tbl[i].level);
      step();
    end
    in_valid = 1'b0;
    step();
    check("bp_full_level", level, 16);
    check("bp_full_ready", in_ready, 0);
    wait_strobe(80, at);
    check("bp_first_data", out_data, 32'hB000_0000);
    check("bp_after_pop_level", level, 15);

    // Disable flushes and holds out_data.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) push_frame(32'hD000_0000 + i);
    wait_strobe(100, at);
    check("dis_pre_data", out_data, 32'hD000_0000);
    check("dis_pre_level", level, 9);
    step();
    enable = 1'b0;
    step();
    check("dis_level", level, 0);
    check("dis_data_held", out_data, 32'hD000_0000);
    check("dis_playing", playing, 0);

    // Asynchronous reset mid-frame.
    enable = 1'b1;
    push_frame(32'hE000_0001);
    push_frame(32'hE000_0002);
    for (int k = 0; k < 64 && m_cnt != 13; k++) step();
    check("ar_pre_level", level, 2);
    check("ar_pre_ready", in_ready, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_data", out_data, 0);
    check("ar_level", level, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_playing", playing, 0);
    check("ar_strobe", out_strobe, 0);
    step();
    rst = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    enable = 1'b1;
    rate = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 4))
          0: rate = 1;
          1: rate = 3;
          2: rate = 5;
          3: rate = 25;
          default: rate = 100;
        endcase
      end
      enable   = ($urandom_range(0, 399) != 0);
      uclr     = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 99) < rate);
      in_data  = $urandom;
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end
    enable = 1'b0; in_valid = 1'b0; uclr = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
